// File: rtl/gshare_resolve_queue_pkg.sv
// Shared types and constants for the gshare predictor and its resolve queue.
// bp_entry_t is laid out at the default history length; other widths use the same field order.
package gshare_pkg;

   localparam int unsigned BP_N       = 7;
   localparam int unsigned PHT_STATES = 4;

   typedef struct packed {
      logic [BP_N-1:0] pc;
      logic            taken;
      logic [BP_N-1:0] history;
   } bp_entry_t;

   // Packed width of one checkpoint {pc, taken, history} for history length n.
   function automatic int unsigned entry_bits(input int unsigned n);
      return 2 * n + 1;
   endfunction

endpackage

// File: rtl/gshare_resolve_queue_if.sv
// Predictor/execute-facing bundle of the resolve queue.
// The master side is the predictor plus execute stage; the slave side is the queue.
interface gshare_resolve_queue_if #(
   parameter int unsigned N     = 7,
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic          predict_valid;
   logic [N-1:0]  predict_pc;
   logic          predict_taken;
   logic [N-1:0]  predict_history;
   logic          alloc_ready;
   logic          resolve_valid;
   logic          resolve_taken;
   logic          resolve_ready;
   logic          train_valid;
   logic          train_taken;
   logic [N-1:0]  train_pc;
   logic [N-1:0]  train_history;
   logic          train_mispredicted;
   logic [CW-1:0] count;

   modport master (
      output predict_valid, predict_pc, predict_taken, predict_history,
      output resolve_valid, resolve_taken,
      input  alloc_ready, resolve_ready,
      input  train_valid, train_taken, train_pc, train_history, train_mispredicted,
      input  count
   );

   modport slave (
      input  predict_valid, predict_pc, predict_taken, predict_history,
      input  resolve_valid, resolve_taken,
      output alloc_ready, resolve_ready,
      output train_valid, train_taken, train_pc, train_history, train_mispredicted,
      output count
   );

endinterface

// File: rtl/gshare_resolve_queue_ckpt_fifo.sv
// In-order checkpoint storage: circular buffer with separate occupancy count.
// Flush clears pointers and count in one cycle and overrides any push or pop.
module gshare_ckpt_fifo #(
   parameter int unsigned W     = 15,
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = AW + 1
) (
   input  logic          clk,
   input  logic          areset_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = tail_q + 1'b1;
         if (pop)  head_d = head_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while count says they are live.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[tail_q] <= wdata;
   end

   assign rdata = mem_q[head_q];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/gshare_resolve_queue.sv
// Checkpoint queue behind the gshare predictor: resolves the oldest branch,
// drives registered training outputs and flushes wrong-path entries on a mispredict.
module gshare_resolve_queue
   import gshare_pkg::*;
#(
   parameter int unsigned N     = 7,
   parameter int unsigned DEPTH = 8
) (
   input logic                  clk,
   input logic                  areset_n,
   gshare_resolve_queue_if.slave bus
);

   localparam int unsigned W  = entry_bits(N);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [N-1:0] pc;
      logic         taken;
      logic [N-1:0] history;
   } entry_t;

   entry_t        wr_entry;
   entry_t        head_entry;
   logic [W-1:0]  head_bits;
   logic          full;
   logic          empty;
   logic          pop;
   logic          mis;
   logic          flush;
   logic          push;
   logic [CW-1:0] count;

   logic         train_valid_q, train_valid_d;
   logic         train_taken_q, train_taken_d;
   logic [N-1:0] train_pc_q, train_pc_d;
   logic [N-1:0] train_history_q, train_history_d;
   logic         train_mis_q, train_mis_d;

   always_comb begin
      wr_entry.pc      = bus.predict_pc;
      wr_entry.taken   = bus.predict_taken;
      wr_entry.history = bus.predict_history;
   end

   assign head_entry = entry_t'(head_bits);

   // Mispredict flush takes priority over a same-cycle push, so the push is dropped here.
   assign pop   = bus.resolve_valid && !empty;
   assign mis   = head_entry.taken != bus.resolve_taken;
   assign flush = pop && mis;
   assign push  = bus.predict_valid && !full && !flush;

   gshare_ckpt_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .areset_n (areset_n),
      .push     (push),
      .pop      (pop),
      .flush    (flush),
      .wdata    (W'(wr_entry)),
      .rdata    (head_bits),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   always_comb begin
      train_valid_d   = pop;
      train_taken_d   = train_taken_q;
      train_pc_d      = train_pc_q;
      train_history_d = train_history_q;
      train_mis_d     = train_mis_q;
      if (pop) begin
         train_taken_d   = bus.resolve_taken;
         train_pc_d      = head_entry.pc;
         train_history_d = head_entry.history;
         train_mis_d     = mis;
      end
   end

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         train_valid_q   <= 1'b0;
         train_taken_q   <= 1'b0;
         train_pc_q      <= '0;
         train_history_q <= '0;
         train_mis_q     <= 1'b0;
      end else begin
         train_valid_q   <= train_valid_d;
         train_taken_q   <= train_taken_d;
         train_pc_q      <= train_pc_d;
         train_history_q <= train_history_d;
         train_mis_q     <= train_mis_d;
      end
   end

   assign bus.alloc_ready        = !full;
   assign bus.resolve_ready      = !empty;
   assign bus.count              = count;
   assign bus.train_valid        = train_valid_q;
   assign bus.train_taken        = train_taken_q;
   assign bus.train_pc           = train_pc_q;
   assign bus.train_history      = train_history_q;
   assign bus.train_mispredicted = train_mis_q;

endmodule

// File: tb/tb_gshare_resolve_queue.sv
// Directed scoreboard bench for gshare_resolve_queue (N=7, DEPTH=8).
module tb_gshare_resolve_queue;
   import gshare_pkg::*;

   typedef struct {
      logic       taken;
      logic [6:0] pc;
      logic [6:0] hist;
      logic       mis;
   } tr_t;

   logic clk = 1'b0;
   logic areset_n;
   int   checks = 0;
   int   errors = 0;

   bp_entry_t mq[$];
   tr_t       exp_q[$];
   tr_t       last_tr;

   gshare_resolve_queue_if #(.N(7), .DEPTH(8)) bus ();

   gshare_resolve_queue #(.N(7), .DEPTH(8)) dut (
      .clk      (clk),
      .areset_n (areset_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      tr_t t;
      if (exp_q.size() != 0) begin
         t = exp_q.pop_front();
         last_tr = t;
         chk("train_valid", 32'(bus.train_valid), 32'd1);
      end else begin
         chk("train_valid", 32'(bus.train_valid), 32'd0);
      end
      chk("train_taken", 32'(bus.train_taken), 32'(last_tr.taken));
      chk("train_pc", 32'(bus.train_pc), 32'(last_tr.pc));
      chk("train_history", 32'(bus.train_history), 32'(last_tr.hist));
      chk("train_mispredicted", 32'(bus.train_mispredicted), 32'(last_tr.mis));
      chk("count", 32'(bus.count), 32'(mq.size()));
      chk("alloc_ready", 32'(bus.alloc_ready), 32'(mq.size() < 8));
      chk("resolve_ready", 32'(bus.resolve_ready), 32'(mq.size() != 0));
   endtask

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      last_tr = '{taken: 1'b0, pc: 7'd0, hist: 7'd0, mis: 1'b0};
   endtask

   // Drives one cycle from a negedge, updates the model at the posedge, checks at the next negedge.
   task automatic cycle(input logic pv, input logic [6:0] pc, input logic pt, input logic [6:0] ph,
                        input logic rv, input logic rt);
      int        sz0;
      logic      flush;
      bp_entry_t e;
      tr_t       t;
      bus.predict_valid   = pv;
      bus.predict_pc      = pv ? pc : 'x;
      bus.predict_taken   = pv ? pt : 1'bx;
      bus.predict_history = pv ? ph : 'x;
      bus.resolve_valid   = rv;
      bus.resolve_taken   = rt;
      @(posedge clk);
      sz0   = mq.size();
      flush = 1'b0;
      if (rv && sz0 != 0) begin
         e = mq.pop_front();
         t.taken = rt;
         t.pc    = e.pc;
         t.hist  = e.history;
         t.mis   = (e.taken != rt);
         exp_q.push_back(t);
         if (t.mis) begin
            flush = 1'b1;
            mq.delete();
         end
      end
      if (pv && sz0 < 8 && !flush) begin
         e.pc      = pc;
         e.taken   = pt;
         e.history = ph;
         mq.push_back(e);
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle();
      cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0);
   endtask

   initial begin
      areset_n            = 1'b0;
      bus.predict_valid   = 1'b0;
      bus.predict_pc      = '0;
      bus.predict_taken   = 1'b0;
      bus.predict_history = '0;
      bus.resolve_valid   = 1'b0;
      bus.resolve_taken   = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      areset_n = 1'b1;

      // Idle resolves on an empty queue must not train.
      for (int i = 0; i < 3; i++) cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b1);

      // Single push then correct resolve.
      cycle(1'b1, 7'h12, 1'b1, 7'h05, 1'b0, 1'b0);
      cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b1);
      idle();

      // Fill to full, then a rejected push alongside a head resolve, then drain.
      for (int i = 0; i < 8; i++)
         cycle(1'b1, 7'(8'h20 + i), 1'(i % 2), 7'(i), 1'b0, 1'b0);
      cycle(1'b1, 7'h7f, 1'b1, 7'h7f, 1'b1, mq[0].taken);
      for (int i = 0; i < 7; i++) cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b1, mq[0].taken);
      idle();

      // Mispredict flush with a dropped same-cycle push, then an ignored resolve.
      for (int i = 1; i <= 4; i++) cycle(1'b1, 7'(i), 1'b1, 7'(8'h10 + i), 1'b0, 1'b0);
      cycle(1'b1, 7'h05, 1'b1, 7'h15, 1'b1, 1'b0);
      cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b1);
      idle();

      // Streaming push+pop every cycle, wrapping the pointers several times.
      cycle(1'b1, 7'h40, 1'b0, 7'h00, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++)
         cycle(1'b1, 7'(8'h41 + i), 1'(i % 2), 7'(8'h30 + i), 1'b1, mq[0].taken);
      cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b1, mq[0].taken);
      idle();

      // Asynchronous reset with entries outstanding.
      for (int i = 0; i < 5; i++) cycle(1'b1, 7'(8'h60 + i), 1'b1, 7'(i), 1'b0, 1'b0);
      bus.predict_valid = 1'b0;
      #2;
      areset_n = 1'b0;
      model_reset();
      #1;
      check_outputs();
      @(negedge clk);
      areset_n = 1'b1;
      cycle(1'b0, 7'd0, 1'b0, 7'd0, 1'b1, 1'b1);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
